l2_line_adapter: RTL and testbench
==================================

Name: l2_line_adapter

Overview:
- Downstream neighbour of the L2 cache: converts the L2's single-transfer 256-bit line interface (pmem side of L2) into a 4-beat, 64-bit burst interface to physical memory.
- Registers the address and write line at request time, counts beats, assembles read lines, and returns a single-cycle line response to the L2 controller.

Parameters:
s_offset, 5, line offset bits; line = 2**s_offset bytes = 256 bits
burst_width, 64, memory burst data width in bits; beats = 256/burst_width = 4

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk)
line_address_i  in  32  line address from L2 (pmem_address)
line_wdata_i  in  256  line to write back (pmem_wdata)
line_rdata_o  out  256  assembled line returned to L2 (pmem_rdata)
line_read_i  in  1  L2 line read request, level, held until line_resp_o
line_write_i  in  1  L2 line write request, level, held until line_resp_o
line_resp_o  out  1  one-cycle completion pulse to L2 (pmem_resp)
burst_address_o  out  32  line-aligned address to memory: latched {addr[31:5],5'b0}
burst_rdata_i  in  64  read beat from memory
burst_wdata_o  out  64  write beat to memory
burst_read_o  out  1  memory read request
burst_write_o  out  1  memory write request
burst_resp_i  in  1  memory beat strobe: a read beat is valid, or a write beat is accepted

Behaviour:
- Reset (rst==0 at an edge): state IDLE, beat counter 0. line_resp_o, burst_read_o and burst_write_o are 0. burst_address_o, burst_wdata_o and line_rdata_o are 0. Reset overrides any in-flight operation; no partial response is given.
- All outputs are registered or are pure decodes of state, counter and latched registers. There is no combinational path from any input to any output.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - line_write_i=1: latch address (offset bits zeroed) and line; go to WR.
  - else line_read_i=1: latch address; go to RD.
  - Simultaneous read and write is illegal from L2; write takes priority.
  - burst_resp_i in IDLE is ignored.
- RD:
  - burst_read_o=1 and burst_address_o is stable for the whole state.
  - Each cycle with burst_resp_i=1 stores burst_rdata_i into line bits [64k+63:64k] (k = beat counter, beat 0 lowest) and increments k.
  - Beats need not be consecutive; cycles without burst_resp_i hold all state.
  - When beat 3 is captured, go to DONE. burst_read_o drops in the DONE cycle.
- WR:
  - burst_write_o=1; burst_wdata_o = latched line bits [64k+63:64k].
  - Each cycle with burst_resp_i=1 counts as beat k accepted; k increments and the next beat is presented the following cycle.
  - After beat 3 is accepted, go to DONE.
- DONE:
  - line_resp_o=1 for exactly this one cycle; line_rdata_o is valid (after a read). Return to IDLE and clear k.
  - line_rdata_o holds its value until the next read overwrites beat 0. Writes do not alter line_rdata_o.
  - Request inputs sampled in DONE are ignored. L2 must drop its request on seeing line_resp_o; a still-high request in the following IDLE cycle starts a new transaction.
- Counter is 2 bits; wraps 3→0 only on the DONE transition.
- burst_resp_i in DONE is ignored.
- Changes to line_address_i or line_wdata_i after latching have no effect on the transaction in flight.
- Minimum latency, with burst_resp_i high on the first request cycle and every cycle after:
  - request sampled at edge 0;
  - burst_read_o/burst_write_o high during cycles 1–4;
  - line_resp_o high in cycle 5.

Test Plan:
- Read, back-to-back beats: line_read_i=1, address 0x1234_5677; memory returns 0x0..0 / 0x1..1 / 0x2..2 / 0x3..3 on 4 consecutive resp cycles → burst_address_o=0x1234_5660; line_resp_o high exactly 1 cycle, 5 cycles after request; line_rdata_o={64'h3..3,64'h2..2,64'h1..1,64'h0..0}.
- Read, gapped beats: burst_resp_i pattern 1,0,0,1,1,0,1 → exactly 4 beats captured in order; burst_read_o held until beat 4; single line_resp_o; no stray capture on gap cycles.
- Write: line_wdata_i = 256'hDDDD..CCCC..BBBB..AAAA (64-bit lanes); memory accepts on alternate cycles → burst_wdata_o sequence AAAA.., BBBB.., CCCC.., DDDD..; each beat stable until accepted; burst_write_o drops after the 4th accept; line_resp_o pulses once.
- Simultaneous line_read_i=line_write_i=1 → WR path taken, burst_read_o never asserted. Separately, line_wdata_i changed mid-write → emitted beats still match the latched line.
- Reset mid-read after 2 beats (rst=0 one cycle) → next cycle all request/resp outputs 0, state IDLE. A subsequent read captures a fresh beat 0 and completes normally with a single line_resp_o.
- burst_resp_i pulses while idle, and request held high through DONE → no capture, no spurious line_resp_o; a new transaction starts only in the cycle after DONE.

Source files
------------

// File: rtl/l2_line_adapter.sv
// Bridges the L2's single 256-bit line transfer onto a 4-beat 64-bit memory burst; min 5 cycles request-to-resp.
// Beats advance only on burst_resp_i; L2 holds its level request until the one-cycle line_resp_o.
module l2_line_adapter #(
    parameter int s_offset    = 5,
    parameter int burst_width = 64,
    localparam int line_width = 8 << s_offset
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            line_address_i,
    input  logic [line_width-1:0]  line_wdata_i,
    output logic [line_width-1:0]  line_rdata_o,
    input  logic                   line_read_i,
    input  logic                   line_write_i,
    output logic                   line_resp_o,
    output logic [31:0]            burst_address_o,
    input  logic [burst_width-1:0] burst_rdata_i,
    output logic [burst_width-1:0] burst_wdata_o,
    output logic                   burst_read_o,
    output logic                   burst_write_o,
    input  logic                   burst_resp_i
);

    localparam int beats = line_width / burst_width;
    localparam int cnt_w = $clog2(beats);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);
    localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [cnt_w-1:0]        beat_q;
    logic [31:0]             addr_q;
    logic [line_width-1:0]   wline_q;
    logic [line_width-1:0]   rline_q;

    logic                    lat_wr;
    logic                    lat_rd;
    logic                    cap_en;
    logic                    beat_adv;
    logic                    beat_clr;
    logic                    beat_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_wr    = 1'b0;
        lat_rd    = 1'b0;
        cap_en    = 1'b0;
        beat_adv  = 1'b0;
        beat_clr  = 1'b0;
        beat_last = (beat_q == last_beat);
        case (state_q)
            IDLE: begin
                // Write wins if L2 ever raises both requests together.
                if (line_write_i) begin
                    lat_wr  = 1'b1;
                    state_d = WR;
                end else if (line_read_i) begin
                    lat_rd  = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (burst_resp_i) begin
                    cap_en = 1'b1;
                    if (beat_last) begin
                        state_d = DONE;
                    end else begin
                        beat_adv = 1'b1;
                    end
                end
            end
            WR: begin
                if (burst_resp_i) begin
                    if (beat_last) begin
                        state_d = DONE;
                    end else begin
                        beat_adv = 1'b1;
                    end
                end
            end
            DONE: begin
                // Counter rests on the last beat until here so the wrap happens only on leaving DONE.
                beat_clr = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            beat_q  <= '0;
        end else begin
            if (lat_wr) begin
                addr_q  <= line_address_i & ~off_mask;
                wline_q <= line_wdata_i;
            end else if (lat_rd) begin
                addr_q  <= line_address_i & ~off_mask;
            end
            if (cap_en) begin
                rline_q[int'(beat_q) * burst_width +: burst_width] <= burst_rdata_i;
            end
            if (beat_clr) begin
                beat_q <= '0;
            end else if (beat_adv) begin
                beat_q <= beat_q + cnt_w'(1);
            end
        end
    end

    assign burst_read_o    = (state_q == RD);
    assign burst_write_o   = (state_q == WR);
    assign line_resp_o     = (state_q == DONE);
    assign burst_address_o = addr_q;
    assign burst_wdata_o   = wline_q[int'(beat_q) * burst_width +: burst_width];
    assign line_rdata_o    = rline_q;

endmodule

// File: tb/tb_l2_line_adapter.sv
// Directed plus randomized line transactions checked against a transaction-level model of the burst bridge.
module tb_l2_line_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  line_address_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_read_i;
    logic         line_write_i;
    logic         line_resp_o;
    logic [31:0]  burst_address_o;
    logic [63:0]  burst_rdata_i;
    logic [63:0]  burst_wdata_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic         burst_resp_i;

    int n_cmp;
    int n_fail;
    logic [255:0] last_line;

    l2_line_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .line_address_i (line_address_i),
        .line_wdata_i   (line_wdata_i),
        .line_rdata_o   (line_rdata_o),
        .line_read_i    (line_read_i),
        .line_write_i   (line_write_i),
        .line_resp_o    (line_resp_o),
        .burst_address_o(burst_address_o),
        .burst_rdata_i  (burst_rdata_i),
        .burst_wdata_o  (burst_wdata_o),
        .burst_read_o   (burst_read_o),
        .burst_write_o  (burst_write_o),
        .burst_resp_i   (burst_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bound(input string tag, input int cyc);
        n_cmp++;
        assert (cyc <= 100)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d cycles expected at most 100", tag, cyc);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    // Caller sits at a negedge with the DUT idle. mode 0: back-to-back directed beats,
    // 1: fixed gap pattern 1,0,0,1,1,0,1, 2: random gaps. Gap cycles carry junk data.
    task automatic run_read(input logic [31:0] addr, input int mode, input bit keep_req);
        logic [255:0] exp_line;
        logic [6:0]   pat;
        int k;
        int cyc;
        bit r;
        pat = 7'b1011001;
        exp_line = last_line;
        line_read_i = 1'b1;
        line_write_i = 1'b0;
        line_address_i = addr;
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < 4) begin
            if (cyc > 100) begin
                check_bound("rd_timeout", cyc);
                break;
            end
            check("rd_req", burst_read_o, 1);
            check("rd_nowr", burst_write_o, 0);
            check("rd_addr", burst_address_o, aligned(addr));
            check("rd_noresp", line_resp_o, 0);
            line_address_i = $urandom;
            case (mode)
                0: r = 1'b1;
                1: r = pat[cyc % 7];
                default: r = 1'($urandom_range(0, 1));
            endcase
            burst_resp_i = r;
            if (mode == 0) burst_rdata_i = {16{k[3:0]}};
            else burst_rdata_i = {$urandom, $urandom};
            if (r) begin
                exp_line[64*k +: 64] = burst_rdata_i;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        burst_resp_i = 1'b0;
        if (mode == 0) check("rd_latency", 256'(cyc), 256'd4);
        if (mode == 1) check("rd_gap_cycles", 256'(cyc), 256'd7);
        check("rd_done_resp", line_resp_o, 1);
        check("rd_done_noreq", burst_read_o, 0);
        check("rd_line", line_rdata_o, exp_line);
        last_line = exp_line;
        if (!keep_req) line_read_i = 1'b0;
        @(negedge clk);
        check("rd_idle_resp", line_resp_o, 0);
        check("rd_idle_req", burst_read_o, 0);
        check("rd_hold_line", line_rdata_o, last_line);
    endtask

    // mode 0: memory accepts on alternate cycles, 1: random acceptance.
    task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input int mode,
                             input bit also_read, input bit alter);
        int k;
        int cyc;
        bit r;
        line_write_i = 1'b1;
        line_read_i = also_read;
        line_address_i = addr;
        line_wdata_i = line;
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < 4) begin
            if (cyc > 100) begin
                check_bound("wr_timeout", cyc);
                break;
            end
            check("wr_req", burst_write_o, 1);
            check("wr_nord", burst_read_o, 0);
            check("wr_addr", burst_address_o, aligned(addr));
            check("wr_beat", burst_wdata_o, line[64*k +: 64]);
            check("wr_noresp", line_resp_o, 0);
            if (alter) begin
                line_wdata_i = rand_line();
                line_address_i = $urandom;
            end
            r = (mode == 0) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
            burst_resp_i = r;
            burst_rdata_i = {$urandom, $urandom};
            if (r) k++;
            @(negedge clk);
            cyc++;
        end
        burst_resp_i = 1'b0;
        if (mode == 0) check("wr_alt_cycles", 256'(cyc), 256'd8);
        check("wr_done_resp", line_resp_o, 1);
        check("wr_done_noreq", burst_write_o, 0);
        check("wr_keeps_rdata", line_rdata_o, last_line);
        line_write_i = 1'b0;
        line_read_i = 1'b0;
        @(negedge clk);
        check("wr_idle_resp", line_resp_o, 0);
        check("wr_idle_req", burst_write_o, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        last_line = '0;
        rst = 1'b0;
        line_address_i = 32'hFFFF_FFFF;
        line_wdata_i = '1;
        line_read_i = 1'b0;
        line_write_i = 1'b1;
        burst_rdata_i = '0;
        burst_resp_i = 1'b1;

        // Reset holds everything quiet even with a request and resp pending.
        repeat (3) @(negedge clk);
        check("rst_resp", line_resp_o, 0);
        check("rst_rd", burst_read_o, 0);
        check("rst_wr", burst_write_o, 0);
        check("rst_addr", burst_address_o, 0);
        check("rst_wdata", burst_wdata_o, 0);
        check("rst_rdata", line_rdata_o, 0);
        line_write_i = 1'b0;
        burst_resp_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", burst_write_o, 0);

        run_read(32'h1234_5677, 0, 1'b0);
        check("rd_directed_line", line_rdata_o,
              {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}});
        run_read(32'hCAFE_0040, 1, 1'b0);

        run_write(32'h8000_003F, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 0, 1'b0, 1'b0);
        run_write(32'h0000_1111, rand_line(), 1, 1'b1, 1'b0);
        run_write(32'h5555_AAAA, rand_line(), 1, 1'b0, 1'b1);

        // Reset in the middle of a read after two beats.
        line_read_i = 1'b1;
        line_address_i = 32'h0BAD_F00D;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("mid_rd_req", burst_read_o, 1);
            burst_resp_i = 1'b1;
            burst_rdata_i = {$urandom, $urandom};
            @(negedge clk);
        end
        burst_resp_i = 1'b0;
        line_read_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rd", burst_read_o, 0);
        check("mid_rst_wr", burst_write_o, 0);
        check("mid_rst_resp", line_resp_o, 0);
        check("mid_rst_addr", burst_address_o, 0);
        check("mid_rst_rdata", line_rdata_o, 0);
        last_line = '0;
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_resp", line_resp_o, 0);
        check("after_rst_rd", burst_read_o, 0);
        run_read(32'h0000_0020, 2, 1'b0);

        // Memory strobes while idle must not capture or respond.
        for (int i = 0; i < 6; i++) begin
            burst_resp_i = 1'($urandom_range(0, 1));
            burst_rdata_i = {$urandom, $urandom};
            @(negedge clk);
            check("idle_resp", line_resp_o, 0);
            check("idle_rd", burst_read_o, 0);
            check("idle_line", line_rdata_o, last_line);
        end
        burst_resp_i = 1'b0;

        // Request left high through DONE starts a second read only after returning to IDLE.
        run_read(32'h7777_7777, 0, 1'b1);
        run_read(32'h7777_7777, 2, 1'b0);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1)
                run_read($urandom, 2, 1'b0);
            else
                run_write($urandom, rand_line(), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_idle_resp", line_resp_o, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
